// File: rtl/uart_word_fifo.sv
// Word FIFO between the parser core and uart_tx: buffers DATA_W-bit results,
// drops and counts words that arrive while full, and drains them through a
// three-state handshake with uart_tx.
module uart_word_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     tx_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [15:0]              drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q,     state_d;
   logic [AW-1:0]     wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q,    rd_ptr_d;
   logic [LW-1:0]     level_q,     level_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              overflow_q,  overflow_d;
   logic [15:0]       drop_cnt_q,  drop_cnt_d;

   logic full_s;
   logic empty_s;
   logic push_s;
   logic drop_s;
   logic pop_s;

   assign full_s  = (level_q == LVL_FULL);
   assign empty_s = (level_q == {LW{1'b0}});

   // A word offered during flush is discarded outright, never counted as a drop.
   assign push_s = in_valid && !full_s && !flush;
   assign drop_s = in_valid &&  full_s && !flush;

   // Drain FSM: pop in IDLE, pulse in SEND, wait for tx_ready low in ACK.
   always_comb begin
      state_d = state_q;
      pop_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_s && tx_ready && !flush) begin
               pop_s   = 1'b1;
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: state_d = ST_ACK;
         ST_ACK: begin
            if (!tx_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACK;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         state_d = state_d;
      end
   end

   // Pointer, occupancy, output and drop bookkeeping.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      out_data_d  = out_data_q;
      out_valid_d = pop_s;
      overflow_d  = overflow_q | drop_s;
      drop_cnt_d  = drop_cnt_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d   = rd_ptr_q + PTR_ONE;
         out_data_d = mem_q[rd_ptr_q];
      end else begin
         rd_ptr_d   = rd_ptr_q;
         out_data_d = out_data_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end

      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         level_d  = {LW{1'b0}};
      end else begin
         level_d  = level_d;
      end
   end

   // Storage array; contents are don't-care after reset so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // Control and status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         level_q     <= {LW{1'b0}};
         out_data_q  <= {DATA_W{1'b0}};
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign in_ready  = !full_s;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_word_fifo.sv
// Directed bench for uart_word_fifo: a vector table for single-cycle behaviour
// plus hand-written burst, overflow, flush, reset and pointer-wrap sequences.
module tb_uart_word_fifo;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] out_data;
   logic        out_valid;
   logic        tx_ready;
   logic [4:0]  level;
   logic        overflow;
   logic [15:0] drop_cnt;

   logic        tx_man;
   logic        tx_model;
   logic        model_en;
   logic [2:0]  busy;

   int          vec_cnt;
   int          err_cnt;
   logic [31:0] rx_q [$];

   typedef struct {
      logic        rst_n;
      logic        flush;
      logic        in_valid;
      logic [31:0] in_data;
      logic        tx_ready;
      logic [4:0]  e_level;
      logic        e_in_ready;
      logic        e_out_valid;
      logic [31:0] e_out_data;
      logic        e_overflow;
      logic [15:0] e_drop;
   } vec_t;

   vec_t tbl [18];

   uart_word_fifo #(.DEPTH(16), .DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .tx_ready  (tx_ready),
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   assign tx_ready = model_en ? tx_model : tx_man;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART stand-in: ready drops after each pulse and returns a few cycles later.
   always @(negedge clk) begin
      if (!model_en) begin
         tx_model <= 1'b1;
         busy     <= 3'd0;
      end else if (out_valid) begin
         tx_model <= 1'b0;
         busy     <= 3'd3;
      end else if (busy != 3'd0) begin
         busy <= busy - 3'd1;
         if (busy == 3'd1) tx_model <= 1'b1;
      end
   end

   // Capture every word handed to the UART.
   always @(negedge clk) begin
      if (out_valid) rx_q.push_back(out_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_rx(input int n, input int bound);
      for (int c = 0; c < bound && rx_q.size() < n; c++) step();
      vec_cnt++;
      if (rx_q.size() < n) begin
         err_cnt++;
         $display("FAIL rx_timeout: got %0d words expected %0d", rx_q.size(), n);
      end
   endtask

   initial begin
      vec_cnt  = 0;
      err_cnt  = 0;
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'h0;
      tx_man   = 1'b0;
      model_en = 1'b0;

      //         rst  fl   iv   data           tx    lvl    rdy   ov    odata          ovf   drop
      tbl[0]  = '{1'b0,1'b0,1'b0,32'h00000000,1'b0, 5'd0,  1'b1,1'b0,32'h00000000,1'b0,16'd0};
      tbl[1]  = '{1'b1,1'b0,1'b1,32'hDEADBEEF,1'b1, 5'd1,  1'b1,1'b0,32'h00000000,1'b0,16'd0};
      tbl[2]  = '{1'b1,1'b0,1'b0,32'h00000000,1'b1, 5'd0,  1'b1,1'b1,32'hDEADBEEF,1'b0,16'd0};
      tbl[3]  = '{1'b1,1'b0,1'b0,32'h00000000,1'b1, 5'd0,  1'b1,1'b0,32'hDEADBEEF,1'b0,16'd0};
      tbl[4]  = '{1'b1,1'b0,1'b0,32'h00000000,1'b0, 5'd0,  1'b1,1'b0,32'hDEADBEEF,1'b0,16'd0};
      tbl[5]  = '{1'b1,1'b0,1'b1,32'h11111111,1'b0, 5'd1,  1'b1,1'b0,32'hDEADBEEF,1'b0,16'd0};
      tbl[6]  = '{1'b1,1'b0,1'b1,32'h22222222,1'b0, 5'd2,  1'b1,1'b0,32'hDEADBEEF,1'b0,16'd0};
      tbl[7]  = '{1'b1,1'b0,1'b0,32'h00000000,1'b1, 5'd1,  1'b1,1'b1,32'h11111111,1'b0,16'd0};
      tbl[8]  = '{1'b1,1'b0,1'b1,32'h33333333,1'b1, 5'd2,  1'b1,1'b0,32'h11111111,1'b0,16'd0};
      tbl[9]  = '{1'b1,1'b0,1'b0,32'h00000000,1'b0, 5'd2,  1'b1,1'b0,32'h11111111,1'b0,16'd0};
      tbl[10] = '{1'b1,1'b0,1'b1,32'h44444444,1'b1, 5'd2,  1'b1,1'b1,32'h22222222,1'b0,16'd0};
      tbl[11] = '{1'b1,1'b0,1'b0,32'h00000000,1'b0, 5'd2,  1'b1,1'b0,32'h22222222,1'b0,16'd0};
      tbl[12] = '{1'b1,1'b0,1'b0,32'h00000000,1'b0, 5'd2,  1'b1,1'b0,32'h22222222,1'b0,16'd0};
      tbl[13] = '{1'b1,1'b1,1'b1,32'h55555555,1'b1, 5'd0,  1'b1,1'b0,32'h22222222,1'b0,16'd0};
      tbl[14] = '{1'b1,1'b0,1'b0,32'h00000000,1'b1, 5'd0,  1'b1,1'b0,32'h22222222,1'b0,16'd0};
      tbl[15] = '{1'b1,1'b0,1'b1,32'hA5A5A5A5,1'b0, 5'd1,  1'b1,1'b0,32'h22222222,1'b0,16'd0};
      tbl[16] = '{1'b1,1'b0,1'b0,32'h00000000,1'b1, 5'd0,  1'b1,1'b1,32'hA5A5A5A5,1'b0,16'd0};
      tbl[17] = '{1'b1,1'b0,1'b0,32'h00000000,1'b0, 5'd0,  1'b1,1'b0,32'hA5A5A5A5,1'b0,16'd0};

      for (int v = 0; v < 18; v++) begin
         rst_n    = tbl[v].rst_n;
         flush    = tbl[v].flush;
         in_valid = tbl[v].in_valid;
         in_data  = tbl[v].in_data;
         tx_man   = tbl[v].tx_ready;
         step();
         chk($sformatf("t%0d_level", v),     32'(level),     32'(tbl[v].e_level));
         chk($sformatf("t%0d_in_ready", v),  32'(in_ready),  32'(tbl[v].e_in_ready));
         chk($sformatf("t%0d_out_valid", v), 32'(out_valid), 32'(tbl[v].e_out_valid));
         chk($sformatf("t%0d_out_data", v),  out_data,       tbl[v].e_out_data);
         chk($sformatf("t%0d_overflow", v),  32'(overflow),  32'(tbl[v].e_overflow));
         chk($sformatf("t%0d_drop_cnt", v),  32'(drop_cnt),  32'(tbl[v].e_drop));
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      tx_man   = 1'b0;

      // Burst of 16 with the UART stalled, then three overflowing words.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rx_q.delete();
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         step();
      end
      in_valid = 1'b0;
      chk("burst_level", 32'(level), 32'd16);
      chk("burst_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h100 + 32'(i);
         step();
      end
      in_valid = 1'b0;
      chk("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_level", 32'(level), 32'd16);

      // One pop, then a push into the freed slot is accepted.
      tx_man = 1'b1;
      step();
      tx_man = 1'b0;
      chk("pop_level", 32'(level), 32'd15);
      chk("pop_out_valid", 32'(out_valid), 32'd1);
      chk("pop_out_data", out_data, 32'd0);
      in_valid = 1'b1;
      in_data  = 32'h200;
      step();
      in_valid = 1'b0;
      chk("refill_level", 32'(level), 32'd16);
      chk("refill_drop_cnt", 32'(drop_cnt), 32'd3);
      step();
      step();
      model_en = 1'b1;
      wait_rx(17, 400);
      for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
         chk($sformatf("burst_word%0d", i), rx_q[i], (i < 16) ? 32'(i) : 32'h200);
      end
      chk("burst_drain_level", 32'(level), 32'd0);

      // Flush while in ACK with five words queued.
      model_en = 1'b0;
      tx_man   = 1'b0;
      step();
      step();
      step();
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h300 + 32'(i);
         step();
      end
      in_valid = 1'b0;
      chk("fl_fill_level", 32'(level), 32'd6);
      tx_man = 1'b1;
      step();
      step();
      chk("fl_ack_level", 32'(level), 32'd5);
      chk("fl_ack_out_valid", 32'(out_valid), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_level", 32'(level), 32'd0);
      chk("fl_drop_cnt", 32'(drop_cnt), 32'd3);
      chk("fl_overflow", 32'(overflow), 32'd1);
      chk("fl_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_data  = 32'hCAFE;
      step();
      in_valid = 1'b0;
      chk("fl_push_level", 32'(level), 32'd1);
      step();
      chk("fl_idle_send", 32'(out_valid), 32'd1);
      chk("fl_idle_data", out_data, 32'hCAFE);

      // Reset asserted for one cycle while in SEND.
      tx_man = 1'b0;
      step();
      step();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h400 + 32'(i);
         step();
      end
      in_valid = 1'b0;
      tx_man   = 1'b1;
      step();
      chk("rs_send_valid", 32'(out_valid), 32'd1);
      chk("rs_send_data", out_data, 32'h400);
      chk("rs_send_level", 32'(level), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n  = 1'b1;
      tx_man = 1'b0;
      chk("rs_out_valid", 32'(out_valid), 32'd0);
      chk("rs_level", 32'(level), 32'd0);
      chk("rs_in_ready", 32'(in_ready), 32'd1);
      chk("rs_out_data", out_data, 32'd0);
      chk("rs_overflow", 32'(overflow), 32'd0);
      chk("rs_drop_cnt", 32'(drop_cnt), 32'd0);

      // Forty words interleaved with drains so both pointers wrap twice.
      rx_q.delete();
      model_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h1000 + 32'(i);
         step();
         in_valid = 1'b0;
         repeat (5) step();
      end
      wait_rx(40, 200);
      chk("wrap_count", 32'(rx_q.size()), 32'd40);
      for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
         chk($sformatf("wrap_word%0d", i), rx_q[i], 32'h1000 + 32'(i));
      end
      chk("wrap_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("wrap_level", 32'(level), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
